// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compares memory read beats against the expected pattern during a
// test session and records a sticky fail flag, a saturating fail count and the first failure.
module bist_response_analyzer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  NbarT,
    input  logic                  start,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  rd_valid,
    input  logic [WIDTH-1:0]      exp_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  last,
    output logic [WIDTH-1:0]      normal_out,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr,
    output logic [WIDTH-1:0]      first_fail_syndrome
);

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } state_t;

    state_t                r_state;
    logic                  r_fail;
    logic [CNT_WIDTH-1:0]  r_fail_count;
    logic [ADDR_WIDTH-1:0] r_first_fail_addr;
    logic [WIDTH-1:0]      r_first_fail_syndrome;

    logic [WIDTH-1:0]      w_syndrome;
    logic                  w_mismatch;
    logic                  w_start_session;

    assign w_syndrome      = mem_rdata ^ exp_data;
    assign w_mismatch      = |w_syndrome;
    assign w_start_session = start && NbarT;

    assign normal_out = NbarT ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= StIdle;
            r_fail                <= 1'b0;
            r_fail_count          <= '0;
            r_first_fail_addr     <= '0;
            r_first_fail_syndrome <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_start_session) begin
                        r_state               <= StCompare;
                        r_fail                <= 1'b0;
                        r_fail_count          <= '0;
                        r_first_fail_addr     <= '0;
                        r_first_fail_syndrome <= '0;
                    end
                end
                StCompare: begin
                    // Abort beats restart, and a restart discards any beat in the same cycle.
                    if (!NbarT) begin
                        r_state <= StIdle;
                    end else if (start) begin
                        r_state               <= StCompare;
                        r_fail                <= 1'b0;
                        r_fail_count          <= '0;
                        r_first_fail_addr     <= '0;
                        r_first_fail_syndrome <= '0;
                    end else if (rd_valid) begin
                        if (w_mismatch) begin
                            r_fail <= 1'b1;
                            if (r_fail_count != {CNT_WIDTH{1'b1}}) begin
                                r_fail_count <= r_fail_count + 1'b1;
                            end
                            if (!r_fail) begin
                                r_first_fail_addr     <= rd_addr;
                                r_first_fail_syndrome <= w_syndrome;
                            end
                        end
                        if (last) begin
                            r_state <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (!NbarT) begin
                        r_state <= StIdle;
                    end else if (start) begin
                        r_state               <= StCompare;
                        r_fail                <= 1'b0;
                        r_fail_count          <= '0;
                        r_first_fail_addr     <= '0;
                        r_first_fail_syndrome <= '0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy                = (r_state == StCompare);
    assign done                = (r_state == StDone);
    assign fail                = r_fail;
    assign fail_count          = r_fail_count;
    assign first_fail_addr     = r_first_fail_addr;
    assign first_fail_syndrome = r_first_fail_syndrome;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Bench for bist_response_analyzer: directed scenarios then random traffic, each cycle checked
// against a session-level reference model (one default instance, one with a 2-bit counter).
module tb_bist_response_analyzer;

    logic       clk = 1'b0;
    logic       rst, NbarT, start, rd_valid, last;
    logic [7:0] mem_rdata, exp_data;
    logic [5:0] rd_addr;

    logic [7:0] normal_out, normal_out_s;
    logic       busy, done, fail, busy_s, done_s, fail_s;
    logic [7:0] fail_count;
    logic [1:0] fail_count_s;
    logic [5:0] first_fail_addr, first_fail_addr_s;
    logic [7:0] first_fail_syndrome, first_fail_syndrome_s;

    int checks = 0;
    int errors = 0;

    // Reference model: session phase plus a plain count of mismatching beats.
    int          m_phase;  // 0 = no session, 1 = collecting, 2 = finished
    int unsigned m_nfail;
    logic [5:0]  m_faddr;
    logic [7:0]  m_fsyn;

    always #5 clk = ~clk;

    bist_response_analyzer dut (
        .clk                (clk),
        .rst                (rst),
        .NbarT              (NbarT),
        .start              (start),
        .mem_rdata          (mem_rdata),
        .rd_valid           (rd_valid),
        .exp_data           (exp_data),
        .rd_addr            (rd_addr),
        .last               (last),
        .normal_out         (normal_out),
        .busy               (busy),
        .done               (done),
        .fail               (fail),
        .fail_count         (fail_count),
        .first_fail_addr    (first_fail_addr),
        .first_fail_syndrome(first_fail_syndrome)
    );

    bist_response_analyzer #(.WIDTH(8), .ADDR_WIDTH(6), .CNT_WIDTH(2)) dut_s (
        .clk                (clk),
        .rst                (rst),
        .NbarT              (NbarT),
        .start              (start),
        .mem_rdata          (mem_rdata),
        .rd_valid           (rd_valid),
        .exp_data           (exp_data),
        .rd_addr            (rd_addr),
        .last               (last),
        .normal_out         (normal_out_s),
        .busy               (busy_s),
        .done               (done_s),
        .fail               (fail_s),
        .fail_count         (fail_count_s),
        .first_fail_addr    (first_fail_addr_s),
        .first_fail_syndrome(first_fail_syndrome_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_edge();
        if (rst) begin
            m_phase = 0;
            m_nfail = 0;
            m_faddr = '0;
            m_fsyn  = '0;
        end else if (m_phase != 0 && !NbarT) begin
            m_phase = 0;
        end else if (start && NbarT) begin
            m_phase = 1;
            m_nfail = 0;
            m_faddr = '0;
            m_fsyn  = '0;
        end else if (m_phase == 1 && rd_valid) begin
            if (mem_rdata != exp_data) begin
                if (m_nfail == 0) begin
                    m_faddr = rd_addr;
                    m_fsyn  = mem_rdata ^ exp_data;
                end
                m_nfail++;
            end
            if (last) m_phase = 2;
        end
    endfunction

    task automatic check_all();
        logic [7:0] exp_norm;
        exp_norm = NbarT ? 8'h00 : mem_rdata;
        chk("normal_out", normal_out, exp_norm);
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("fail", fail, m_nfail != 0);
        chk("fail_count", fail_count, (m_nfail > 255) ? 255 : m_nfail);
        chk("first_fail_addr", first_fail_addr, m_faddr);
        chk("first_fail_syndrome", first_fail_syndrome, m_fsyn);
        chk("s_busy", busy_s, m_phase == 1);
        chk("s_done", done_s, m_phase == 2);
        chk("s_fail_count", fail_count_s, (m_nfail > 3) ? 3 : m_nfail);
        chk("s_first_fail_addr", first_fail_addr_s, m_faddr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic beat(input logic [5:0] a, input logic [7:0] rd, input logic [7:0] ex,
                        input logic lst);
        rd_valid  = 1'b1;
        rd_addr   = a;
        mem_rdata = rd;
        exp_data  = ex;
        last      = lst;
        tick();
        rd_valid  = 1'b0;
        last      = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; NbarT = 1'b0; start = 1'b0; rd_valid = 1'b0; last = 1'b0;
        mem_rdata = '0; exp_data = '0; rd_addr = '0;
        m_phase = 0; m_nfail = 0; m_faddr = '0; m_fsyn = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_count", fail_count, 8'd0);

        // Functional path routing
        mem_rdata = 8'hAA;
        tick();
        chk("norm_pass", normal_out, 8'hAA);
        NbarT = 1'b1;
        tick();
        chk("norm_test", normal_out, 8'h00);
        chk("norm_busy", busy, 1'b0);

        // Start in normal mode is ignored
        NbarT = 1'b0;
        pulse_start();
        chk("start_nm_ignored", busy, 1'b0);
        NbarT = 1'b1;

        // Clean session
        pulse_start();
        chk("clean_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) beat(6'(i), 8'h55, 8'h55, i == 3);
        chk("clean_done", done, 1'b1);
        chk("clean_fail", fail, 1'b0);
        chk("clean_count", fail_count, 8'd0);

        // Two errors, first one captured
        pulse_start();
        beat(6'd4, 8'h12, 8'h12, 1'b0);
        beat(6'd5, 8'hFF, 8'hF0, 1'b0);
        tick();
        beat(6'd9, 8'h00, 8'h01, 1'b1);
        chk("err_fail", fail, 1'b1);
        chk("err_count", fail_count, 8'd2);
        chk("err_addr", first_fail_addr, 6'd5);
        chk("err_syn", first_fail_syndrome, 8'h0F);

        // Beats in DONE are ignored and results held
        beat(6'd1, 8'h00, 8'hFF, 1'b1);
        chk("done_hold_count", fail_count, 8'd2);

        // Saturation of the 2-bit counter
        pulse_start();
        for (int i = 0; i < 6; i++) beat(6'(i + 10), 8'(i), 8'(i) ^ 8'h80, i == 5);
        chk("sat_small", fail_count_s, 2'd3);
        chk("sat_big", fail_count, 8'd6);

        // Restart mid-session; simultaneous beat is discarded
        pulse_start();
        beat(6'd2, 8'h01, 8'h02, 1'b0);
        beat(6'd3, 8'h01, 8'h04, 1'b0);
        start = 1'b1;
        beat(6'd7, 8'h00, 8'hFF, 1'b0);
        start = 1'b0;
        chk("restart_count", fail_count, 8'd0);
        chk("restart_busy", busy, 1'b1);

        // Abort by leaving test mode
        beat(6'd8, 8'h33, 8'h30, 1'b0);
        NbarT = 1'b0;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_count", fail_count, 8'd1);
        chk("abort_syn", first_fail_syndrome, 8'h03);
        NbarT = 1'b1;

        // Reset mid-session after one mismatch
        pulse_start();
        beat(6'd6, 8'hF0, 8'h0F, 1'b0);
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        chk("rst_fail", fail, 1'b0);
        chk("rst_busy", busy, 1'b0);
        beat(6'd6, 8'hF0, 8'h0F, 1'b1);
        chk("rst_ignore_count", fail_count, 8'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            NbarT     = ($urandom_range(0, 24) != 0);
            start     = ($urandom_range(0, 19) == 0);
            rd_valid  = $urandom_range(0, 1) == 1;
            last      = ($urandom_range(0, 9) == 0);
            rd_addr   = 6'($urandom);
            mem_rdata = 8'($urandom);
            exp_data  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : mem_rdata;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
